lcd_hd44780_ctrl: RTL and testbench
===================================

# lcd_hd44780_ctrl

Parametrised Avalon-MM slave driving an HD44780-compatible character LCD (16207 class) in 8-bit or 4-bit bus mode. Unlike a purely combinational bridge, it generates the LCD bus timing itself: address setup, enable pulse width and hold are counted in clock cycles, and `waitrequest` stalls the master until the bus cycle completes. It sits between the Nios II system interconnect and the board LCD header and needs no software delay loops for bus timing.

## Interface
- `BUS_W`, 8: LCD data bus width; 8 = 8-bit mode, 4 = 4-bit mode (two nibble cycles per access). Other values are illegal.
- `SETUP_CYCLES`, 2: clocks with RS/RW valid and E low before the E rising edge (tAS); ≥1.
- `E_HIGH_CYCLES`, 12: clocks E is held high (PWEH); ≥1.
- `HOLD_CYCLES`, 2: clocks after the E falling edge with RS/RW/data held (tAH/tH); ≥1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  bit 0 = RW (1 read), bit 1 = RS (1 data register).
- `read`  in  1  Avalon read request.
- `write`  in  1  Avalon write request.
- `writedata`  in  8  byte to write.
- `readdata`  out  8  byte read; valid in the cycle `waitrequest` is low for a read.
- `waitrequest`  out  1  stall; the master holds its request until this is low.
- `LCD_E`  out  1  enable strobe, registered.
- `LCD_RS`  out  1  register select, registered.
- `LCD_RW`  out  1  read/not-write, registered.
- `LCD_data`  inout  BUS_W  LCD data bus, tri-stated unless this block is driving it.

## Operation
- The FSM states are IDLE, SETUP, EHIGH, HOLD and DONE. A single down-counter is reloaded on each state entry. A nibble flag tracks 4-bit mode.
- IDLE: when `read|write` is high, latch `address`, `writedata` and `op = address[0]`, load the RS/RW registers, then go to SETUP. Clear the nibble flag, which means the high nibble comes first.
- SETUP: stay for SETUP_CYCLES, then go to EHIGH.
- EHIGH: stay for E_HIGH_CYCLES. On the last EHIGH cycle, when op is a read, capture `LCD_data` into the shift register. Then go to HOLD.
- HOLD: stay for HOLD_CYCLES.
  - When BUS_W=4 and the nibble flag is clear, set the flag and go to SETUP.
  - Otherwise, go to DONE.
- DONE: lasts exactly 1 cycle, then returns to IDLE.
- `LCD_E` = 1 only in EHIGH.
- `LCD_data` drive:
  - It is driven only in SETUP, EHIGH and HOLD of a write op; it is Z otherwise.
  - In 8-bit mode, the driven value is the latched byte.
  - In 4-bit mode, the driven value is `byte[7:4]` on the first nibble and `byte[3:0]` on the second.
- Read data: 8-bit mode uses the captured byte. 4-bit mode assembles `{first_nibble, second_nibble}`.
- `readdata` is registered. It updates on entry to DONE for reads and otherwise holds its value.
- `waitrequest` = `(read|write) & (state != DONE)`. It is combinational from the request and the registered state.
- The master must hold `address`/`writedata` stable while stalled. The block uses its latched copies regardless.
- A request seen in the cycle after DONE is a new, independent transfer. Back-to-back accesses therefore have no forced gap beyond IDLE.
- `read` and `write` both high: treated as the operation given by `address[0]`.
- A request deasserted mid-transfer is illegal Avalon behaviour. The FSM completes the LCD cycle anyway and never leaves E high.

## Timing
- Reset values (applied on the reset clock edge from any state):
  - state = IDLE
  - `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=1
  - `LCD_data`=Z
  - `readdata`=0, nibble flag=0
- Reset mid-transfer aborts immediately: E drops low on the next edge and no DONE cycle is produced.
- Let N = 1 (8-bit) or 2 (4-bit) and P = SETUP_CYCLES+E_HIGH_CYCLES+HOLD_CYCLES. With the request first seen in cycle 0, `waitrequest` is low in cycle 1+N·P.
- `LCD_RS`/`LCD_RW` are valid from cycle 1 until DONE.
- E rises at cycle 1+SETUP_CYCLES and is high for exactly E_HIGH_CYCLES per nibble.
- In 4-bit mode, E has HOLD_CYCLES+SETUP_CYCLES low cycles between its two pulses.
- Counters are sized to $clog2(max parameter + 1).

## Test plan
- 8-bit write with defaults (address=2'b10, writedata=8'h41):
  - `waitrequest` is low exactly in cycle 17.
  - RS=1, RW=0, E is high for cycles 3–14.
  - `LCD_data`=8'h41 during cycles 1–16 and Z otherwise.
- 8-bit read (address=2'b01) with the LCD model driving 8'h80:
  - `readdata`=8'h80 in cycle 17.
  - `LCD_data` is never driven by the DUT.
- BUS_W=4 write of 8'hA5:
  - There are two E pulses.
  - The bus shows 4'hA for the first pulse, then 4'h5.
  - `waitrequest` is low in cycle 33.
- BUS_W=4 read with the model returning 4'h3 then 4'hC:
  - `readdata`=8'h3C.
- Reset asserted while in EHIGH:
  - `LCD_E`=0 and `LCD_data`=Z on the next edge.
  - The next request completes normally with full timing.
- Back-to-back writes 8'h01 then 8'h02 with the request reasserted the cycle after DONE:
  - Second `waitrequest` low at cycle 35.
  - Each E pulse is exactly 12 cycles.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl
// Avalon-MM slave that runs HD44780-style LCD bus cycles in 8-bit or 4-bit
// mode. The controller counts address setup, enable pulse width and hold in
// clock cycles. It keeps waitrequest high until the LCD cycle has finished.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   address[1:0] bit 0 = RW (1 read), bit 1 = RS (1 data register)
//   read, write  Avalon requests; both high acts as the op in address[0]
//   writedata    byte to send to the LCD
//   readdata     byte read back; updated on entry to DONE for reads
//   waitrequest  stall, low only in the DONE cycle while a request is held
//   LCD_E        enable strobe (registered)
//   LCD_RS       register select (registered)
//   LCD_RW       read/not-write (registered)
//   LCD_data     tri-state LCD data bus, BUS_W bits wide
module lcd_hd44780_ctrl #(
  parameter int BUS_W         = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             waitrequest,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  inout  wire  [BUS_W-1:0] LCD_data
);

  localparam int MAX_SE = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_C  = (MAX_SE > HOLD_CYCLES) ? MAX_SE : HOLD_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  // The counter is loaded with length-1 so that the state ends on zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             nibble, nibble_next;
  logic             op;        // 1 = read
  logic             start;     // a request is being accepted this cycle
  logic             capture;   // sample LCD_data at the end of the E pulse
  logic             op_next;
  logic             drive;
  logic [7:0]       data_q;
  logic [7:0]       shreg;
  logic [7:0]       shift_in;
  logic [BUS_W-1:0] bus_out;

  // Mode-dependent data paths. In 4-bit mode the high nibble travels first.
  if (BUS_W == 4) begin : g_nibble
    assign shift_in = {shreg[3:0], LCD_data};
    assign bus_out  = nibble ? data_q[3:0] : data_q[7:4];
  end else begin : g_byte
    assign shift_in = LCD_data;
    assign bus_out  = data_q;
  end

  assign LCD_data    = drive ? bus_out : {BUS_W{1'bz}};
  assign waitrequest = (read | write) & (state != DONE);
  assign op_next     = start ? address[0] : op;

  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // skips an assignment would otherwise infer a latch.
    next_state  = state;
    cnt_next    = cnt;
    nibble_next = nibble;
    start       = 1'b0;
    capture     = 1'b0;
    unique case (state)
      IDLE: if (read | write) begin
        start       = 1'b1;
        nibble_next = 1'b0;
        next_state  = SETUP;
        cnt_next    = SETUP_LD;
      end
      SETUP: if (cnt == '0) begin
        next_state = EHIGH;
        cnt_next   = EHIGH_LD;
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
      EHIGH: if (cnt == '0) begin
        capture    = op;
        next_state = HOLD;
        cnt_next   = HOLD_LD;
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
      HOLD: if (cnt == '0) begin
        if (BUS_W == 4 && !nibble) begin
          nibble_next = 1'b1;
          next_state  = SETUP;
          cnt_next    = SETUP_LD;
        end else begin
          next_state = DONE;
        end
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    // This keeps every register sampling values from before the edge.
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      nibble   <= 1'b0;
      op       <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b1;
      drive    <= 1'b0;
      data_q   <= '0;
      shreg    <= '0;
      readdata <= '0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      nibble <= nibble_next;
      if (start) begin
        op     <= address[0];
        LCD_RS <= address[1];
        LCD_RW <= address[0];
        data_q <= writedata;
      end
      // E and the bus enable are decoded from the next state. This keeps both
      // registered and aligned with the state they belong to.
      LCD_E <= (next_state == EHIGH);
      drive <= !op_next && (next_state == SETUP || next_state == EHIGH ||
                            next_state == HOLD);
      if (capture) shreg <= shift_in;
      if (next_state == DONE && op) readdata <= shreg;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl
// Directed bench for lcd_hd44780_ctrl. It drives one 8-bit instance and one
// 4-bit instance. Undriven bus lines are pulled high, so a released bus reads
// as all ones. An LCD model drives the bus whenever E and RW are both high.
// Each access pushes its expected completion cycle and readdata to a
// scoreboard. The entry is popped when waitrequest drops.
module tb_lcd_hd44780_ctrl;

  localparam int S  = 2;
  localparam int EH = 12;
  localparam int H  = 2;
  localparam int P  = S + EH + H;

  typedef struct {
    logic [7:0] rd;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       read8, write8, read4, write4;
  logic [7:0] readdata8, readdata4;
  logic       wr8, wr4, e8, e4, rs8, rs4, rw8, rw4;
  wire  [7:0] bus8;
  wire  [3:0] bus4;
  logic [7:0] resp8;
  logic [3:0] resp4;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc_ctr     = 0;
  logic [7:0] exp_rd8     = 8'h00;
  logic [7:0] exp_rd4     = 8'h00;

  always #5 clk = ~clk;
  always @(negedge clk) cyc_ctr++;

  for (genvar i = 0; i < 8; i++) begin : g_pu8
    pullup (bus8[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_pu4
    pullup (bus4[i]);
  end

  // LCD model: drives read data while E is high on a read cycle.
  assign bus8 = (e8 && rw8) ? resp8 : 8'bz;
  assign bus4 = (e4 && rw4) ? resp4 : 4'bz;

  lcd_hd44780_ctrl #(.BUS_W(8), .SETUP_CYCLES(S), .E_HIGH_CYCLES(EH), .HOLD_CYCLES(H)) dut8 (
    .clk(clk), .reset(reset), .address(address), .read(read8), .write(write8),
    .writedata(writedata), .readdata(readdata8), .waitrequest(wr8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(bus8)
  );

  lcd_hd44780_ctrl #(.BUS_W(4), .SETUP_CYCLES(S), .E_HIGH_CYCLES(EH), .HOLD_CYCLES(H)) dut4 (
    .clk(clk), .reset(reset), .address(address), .read(read4), .write(write4),
    .writedata(writedata), .readdata(readdata4), .waitrequest(wr4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(bus4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access. Request is raised on the first negedge (cycle 0).
  // keep leaves the request asserted so the next call starts the cycle after DONE.
  task automatic access(input bit m4, input logic [1:0] a, input logic [7:0] wd,
                        input logic [7:0] resp, input bit keep, input bit both,
                        output int start_c, output int done_c);
    int         n;
    int         last;
    int         k;
    int         ph;
    bit         done;
    bit         exp_e;
    logic [7:0] exp_bus;
    logic [7:0] obs_bus;
    exp_t       item;
    exp_t       got;
    n    = m4 ? 2 : 1;
    last = n * P;
    @(posedge clk);
    @(negedge clk);
    start_c   = cyc_ctr;
    done_c    = -1;
    address   = a;
    writedata = wd;
    resp8     = resp;
    resp4     = resp[7:4];
    if (m4) begin
      if (a[0]) exp_rd4 = resp;
      item.rd = exp_rd4;
      read4   = a[0] | both;
      write4  = ~a[0] | both;
    end else begin
      if (a[0]) exp_rd8 = resp;
      item.rd = exp_rd8;
      read8   = a[0] | both;
      write8  = ~a[0] | both;
    end
    item.done_cyc = 1 + last;
    sb.push_back(item);
    #1;
    check("wait_c0", {7'd0, m4 ? wr4 : wr8}, 8'd1);
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      k     = (c - 1) / P;
      ph    = (c - 1) % P;
      exp_e = (c <= last) && (ph >= S) && (ph < S + EH);
      if (c <= last && !a[0])
        exp_bus = m4 ? {4'h0, (k == 0) ? wd[7:4] : wd[3:0]} : wd;
      else if (exp_e && a[0])
        exp_bus = m4 ? {4'h0, (k == 0) ? resp[7:4] : resp[3:0]} : resp;
      else
        exp_bus = m4 ? 8'h0F : 8'hFF;
      obs_bus = m4 ? {4'h0, bus4} : bus8;
      check($sformatf("lcd_e c%0d", c), {7'd0, m4 ? e4 : e8}, {7'd0, exp_e});
      check($sformatf("lcd_data c%0d", c), obs_bus, exp_bus);
      check($sformatf("rs_rw c%0d", c), {6'd0, m4 ? rs4 : rs8, m4 ? rw4 : rw8}, {6'd0, a});
      if (!(m4 ? wr4 : wr8)) begin
        got = sb.pop_front();
        check("done_cycle", 8'(c), 8'(got.done_cyc));
        check("readdata", m4 ? readdata4 : readdata8, got.rd);
        done   = 1'b1;
        done_c = cyc_ctr;
      end
      if (c >= P) resp4 = resp[3:0];
    end
    check("done_seen", {7'd0, done}, 8'd1);
    if (!done) void'(sb.pop_front());
    if (!keep) begin
      read8 = 0; write8 = 0; read4 = 0; write4 = 0;
    end
  endtask

  initial begin
    int s0, d0, s1, d1;
    reset = 1'b1; address = 2'b00; writedata = 8'h00;
    read8 = 0; write8 = 0; read4 = 0; write4 = 0;
    resp8 = 8'h00; resp4 = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_e", {6'd0, e8, e4}, 8'd0);
    check("rst_rs", {6'd0, rs8, rs4}, 8'd0);
    check("rst_rw", {6'd0, rw8, rw4}, 8'd3);
    check("rst_rd8", readdata8, 8'h00);
    check("rst_rd4", readdata4, 8'h00);
    check("rst_bus8", bus8, 8'hFF);
    check("rst_bus4", {4'h0, bus4}, 8'h0F);
    check("rst_wait", {6'd0, wr8, wr4}, 8'd0);
    reset = 1'b0;

    access(0, 2'b10, 8'h41, 8'h00, 0, 0, s0, d0);   // 8-bit data write
    access(0, 2'b01, 8'h00, 8'h80, 0, 0, s0, d0);   // 8-bit busy/address read
    access(1, 2'b10, 8'hA5, 8'h00, 0, 0, s0, d0);   // 4-bit write, two pulses
    access(1, 2'b01, 8'h00, 8'h3C, 0, 0, s0, d0);   // 4-bit read, 3 then C

    // Reset while E is high: E and the bus drop on the next edge.
    @(posedge clk);
    @(negedge clk);
    address = 2'b10; writedata = 8'h55; write8 = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_e", {7'd0, e8}, 8'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_e", {7'd0, e8}, 8'd0);
    check("abort_bus", bus8, 8'hFF);
    check("abort_rs_rw", {6'd0, rs8, rw8}, 8'd1);
    check("abort_rd8", readdata8, 8'h00);
    check("abort_rd4", readdata4, 8'h00);
    reset = 1'b0; write8 = 0;
    exp_rd8 = 8'h00; exp_rd4 = 8'h00;
    access(0, 2'b10, 8'h48, 8'h00, 0, 0, s0, d0);   // full timing after abort

    // Back-to-back writes; the second request is seen the cycle after DONE.
    access(0, 2'b00, 8'h01, 8'h00, 1, 0, s0, d0);
    access(0, 2'b00, 8'h02, 8'h00, 0, 0, s1, d1);
    check("b2b_second_done", 8'(d1 - s0), 8'd35);

    // read and write together follow address[0].
    access(0, 2'b10, 8'h7E, 8'h00, 0, 1, s0, d0);
    access(1, 2'b01, 8'h00, 8'hD2, 0, 1, s0, d0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
